// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB-to-gray frame controller.
//   state_t          : controller FSM encoding (IDLE, RUN, DRAIN, DONE)
//   RGB_W / GRAY_W   : pixel widths on the RGB read side and gray write side
//   *_DEF            : default values for the controller parameters
package rgb_pkg;

  localparam int RGB_W          = 24;
  localparam int GRAY_W         = 8;
  localparam int NUM_PIX_DEF    = 76800;  // 320x240
  localparam int ADDR_W_DEF     = 17;
  localparam int PIPE_LAT_DEF   = 3;      // 1 memory + 2 datapath cycles
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gray_fifo.sv
// Synchronous result buffer between the gray datapath and the gray memory.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset (clears pointers/count)
//   push       : store push_data this cycle
//   push_data  : gray pixel to store
//   pop        : consume the head entry this cycle
//   head       : oldest stored entry (undefined while empty)
//   count      : number of stored entries
//   empty      : count == 0
// A push into an empty buffer only becomes visible at head/count on the
// following cycle; there is no fall-through path.
module gray_fifo
  import rgb_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  parameter  int W     = GRAY_W,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push while full is dropped; the credit scheme upstream must make it
  // impossible, and the assertion below flags it if it ever happens.
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst) !(push && full));

endmodule

// File: rtl/rgb_frame_ctrl.sv
// Frame sequencer: reads every RGB pixel of a frame, feeds it through an
// external RGB-to-gray datapath and writes the gray result to gray memory
// in the same raster order.
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   start               : frame request, only looked at in IDLE
//   rd_en, rd_addr      : RGB memory read strobe / pixel index
//   rd_data             : RGB pixel, valid the cycle after rd_en
//   dp_data, dp_start   : datapath input (registered rd_data) and enable
//   gray_in             : datapath result, valid PIPE_LAT cycles after rd_en
//   wr_en, wr_addr,
//   wr_data, wr_stall   : gray memory write port with stall
//   busy, done          : frame in progress / one-cycle completion pulse
//   dbg_state           : current FSM state
// Handshakes: rd_en is a bare strobe with no back-pressure; a read is
// issued in every cycle rd_en=1. On the write side a write is transferred
// in exactly the cycles where wr_en=1, and wr_en is never raised while
// wr_stall=1 (wr_stall plays the role of an inverted ready). Reads are
// only issued while reads in flight plus buffered results leave room in
// the result buffer, so a stalled write port can never cause data loss.
module rgb_frame_ctrl
  import rgb_pkg::*;
#(
  parameter int NUM_PIX    = NUM_PIX_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RGB_W-1:0]  rd_data,
  output logic [RGB_W-1:0]  dp_data,
  output logic              dp_start,
  input  logic [GRAY_W-1:0] gray_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [GRAY_W-1:0] wr_data,
  input  logic              wr_stall,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(PIPE_LAT + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

  state_t              state;
  logic [ADDR_W-1:0]   rd_cnt;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [PIPE_LAT-1:0] tags;
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [GRAY_W-1:0]   fifo_head;
  logic                tag_exit;
  logic [SUM_W-1:0]    credit_used;

  // The oldest tag marks the cycle in which gray_in carries a real result.
  assign tag_exit    = tags[PIPE_LAT-1];
  // Every issued read owns one buffer slot from issue until it is written,
  // so the slot budget is reads in flight plus entries already buffered.
  assign credit_used = SUM_W'(inflight) + SUM_W'(fifo_count);

  assign rd_en     = (state == ST_RUN) && (credit_used < SUM_W'(FIFO_DEPTH));
  assign rd_addr   = rd_cnt;
  assign wr_en     = !fifo_empty && !wr_stall;
  assign wr_addr   = wr_cnt;
  assign wr_data   = wr_en ? fifo_head : '0;
  assign dp_start  = (state == ST_RUN) || (state == ST_DRAIN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      tags     <= '0;
      inflight <= '0;
      dp_data  <= '0;
    end else begin
      dp_data  <= rd_data;
      tags     <= (tags << 1) | PIPE_LAT'(rd_en);
      inflight <= inflight + INF_W'(rd_en) - INF_W'(tag_exit);

      // Counters saturate at the last pixel; the state change ends the frame.
      if (wr_en && (wr_cnt != LAST)) wr_cnt <= wr_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= '0;
            tags     <= '0;
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            if (rd_cnt == LAST) state <= ST_DRAIN;
            else                rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (wr_en && (wr_cnt == LAST)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  gray_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (GRAY_W)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (tag_exit),
    .push_data (gray_in),
    .pop       (wr_en),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_rgb_frame_ctrl.sv
// Directed bench for rgb_frame_ctrl with an 8-pixel frame.
// RGB memory model: rd_data registered one cycle after rd_en.
// Datapath model: one register on dp_data, gray = R channel, which gives
// the 3-cycle rd_en -> gray_in latency the controller expects.
module tb_rgb_frame_ctrl;
  import rgb_pkg::*;

  localparam int NUM_PIX    = 8;
  localparam int ADDR_W     = 17;
  localparam int PIPE_LAT   = 3;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data = '0;
  logic [23:0]       dp_data;
  logic              dp_start;
  logic [7:0]        gray_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_stall = 1'b0;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  int n_vec = 0;
  int n_err = 0;

  rgb_frame_ctrl #(
    .NUM_PIX    (NUM_PIX),
    .ADDR_W     (ADDR_W),
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dp_data   (dp_data),
    .dp_start  (dp_start),
    .gray_in   (gray_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_stall  (wr_stall),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- memory and datapath models ----------------
  logic [23:0] pix_mem [NUM_PIX];
  logic [7:0]  gray_q = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= pix_mem[rd_addr[2:0]];
    gray_q <= dp_data[23:16];
  end
  assign gray_in = gray_q;

  // ---------------- monitor / scoreboard logs ----------------
  logic [ADDR_W-1:0] wa_log[$];
  logic [7:0]        wd_log[$];
  logic [7:0]        exp_q[$];
  int cyc, done_cnt, rd_cnt_m, max_cnt, credit_viol, first_rd, done_at;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
    if (rd_en) begin
      rd_cnt_m++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
    if (rd_en && (int'(u_dut.inflight) + int'(u_dut.fifo_count) >= FIFO_DEPTH)) credit_viol++;
  end

  task automatic clear_logs();
    wa_log.delete();
    wd_log.delete();
    exp_q.delete();
    cyc = 0; done_cnt = 0; rd_cnt_m = 0; max_cnt = 0; credit_viol = 0;
    first_rd = -1; done_at = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rd_en, rd_addr, dp_data, dp_start, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {rd_en, rd_addr, dp_data, dp_start, wr_en, wr_addr, wr_data, busy, done});
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, rd_en, done} !== 3'b000) begin
      n_err++; $display("FAIL idle_no_start: got busy/rd_en/done=%b want 000", {busy, rd_en, done});
    end
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 24'h010101 * 24'(i);
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(8'(i));
    pulse_start();
    @(negedge clk);
    n_vec++;
    if ({busy, dp_start, rd_en, rd_addr} !== {3'b111, 17'd0}) begin
      n_err++; $display("FAIL basic_first_read: got %b/%0d want 111/0", {busy, dp_start, rd_en}, rd_addr);
    end
    wait_done(100, to);
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got timeout want done"); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL basic_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if (wa_log[i] !== ADDR_W'(i)) begin
        n_err++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, wa_log[i], i);
      end
      n_vec++;
      if (wd_log[i] !== exp_q[i]) begin
        n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, wd_log[i], exp_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_cycles: got %0d want 1", done_cnt); end
    // First read strobe to done pulse.
    n_vec++;
    if (done_at - first_rd !== NUM_PIX + PIPE_LAT + 2) begin
      n_err++; $display("FAIL basic_latency: got %0d want %0d", done_at - first_rd, NUM_PIX + PIPE_LAT + 2);
    end
    n_vec++;
    if (credit_viol !== 0) begin n_err++; $display("FAIL basic_credit: got %0d want 0", credit_viol); end
    n_vec++;
    if ({busy, dp_start, done} !== 3'b000) begin
      n_err++; $display("FAIL basic_after_done: got %b want 000", {busy, dp_start, done});
    end
  endtask

  task automatic test_stall_hold();
    bit to;
    int late_rd;
    int stall_wr;
    int cnt_end;
    late_rd = 0; stall_wr = 0; cnt_end = 0;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = {8'h20 + 8'(i), 8'h5A, 8'hC3};
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(8'h20 + 8'(i));
    pulse_start();
    repeat (2) @(posedge clk);
    #1 wr_stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 5 && rd_en) late_rd++;
      if (wr_en) stall_wr++;
      if (k == 10) cnt_end = int'(u_dut.fifo_count);
    end
    @(posedge clk);
    #1 wr_stall = 1'b0;
    wait_done(100, to);
    n_vec++;
    if (late_rd !== 0) begin n_err++; $display("FAIL stall_reads_stop: got %0d want 0", late_rd); end
    n_vec++;
    if (stall_wr !== 0) begin n_err++; $display("FAIL stall_no_write: got %0d want 0", stall_wr); end
    n_vec++;
    if (cnt_end !== FIFO_DEPTH) begin n_err++; $display("FAIL stall_fifo_full: got %0d want %0d", cnt_end, FIFO_DEPTH); end
    n_vec++;
    if (credit_viol !== 0) begin n_err++; $display("FAIL stall_credit: got %0d want 0", credit_viol); end
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got timeout want done"); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL stall_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if ({wa_log[i], wd_log[i]} !== {ADDR_W'(i), exp_q[i]}) begin
        n_err++; $display("FAIL stall_write[%0d]: got %0d/%h want %0d/%h", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_stall_toggle();
    bit to;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = {8'h80 + 8'(3 * i), 8'h00, 8'hFF};
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(8'h80 + 8'(3 * i));
    pulse_start();
    to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1 wr_stall = ~wr_stall;
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    wr_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL toggle_timeout: got timeout want done"); end
    n_vec++;
    if (max_cnt > FIFO_DEPTH) begin n_err++; $display("FAIL toggle_max_count: got %0d want <=%0d", max_cnt, FIFO_DEPTH); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL toggle_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if ({wa_log[i], wd_log[i]} !== {ADDR_W'(i), exp_q[i]}) begin
        n_err++; $display("FAIL toggle_write[%0d]: got %0d/%h want %0d/%h", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL toggle_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    bit to;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = {8'h40 + 8'(i), 8'(i), 8'h11};
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(8'h40 + 8'(i));
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(100, to);
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL restart_timeout: got timeout want done"); end
    n_vec++;
    if (rd_cnt_m !== NUM_PIX) begin n_err++; $display("FAIL restart_reads: got %0d want %0d", rd_cnt_m, NUM_PIX); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL restart_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if ({wa_log[i], wd_log[i]} !== {ADDR_W'(i), exp_q[i]}) begin
        n_err++; $display("FAIL restart_write[%0d]: got %0d/%h want %0d/%h", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    n_vec++;
    if ({busy, dbg_state} !== {1'b0, ST_IDLE}) begin
      n_err++; $display("FAIL restart_idle_after: got busy=%b state=%0d want 0/%0d", busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_extremes();
    bit to;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
    pulse_start();
    wait_done(100, to);
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL extreme_timeout: got timeout want done"); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL extreme_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if ({wa_log[i], wd_log[i]} !== {ADDR_W'(i), exp_q[i]}) begin
        n_err++; $display("FAIL extreme_write[%0d]: got %0d/%h want %0d/%h", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit found;
    for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = {8'hA0 + 8'(i), 8'h33, 8'h44};
    clear_logs();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_en && rd_addr == ADDR_W'(4)) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (found !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_pix4: got not reached want reached"); end
    #2 n_rst = 1'b0;
    #1;
    n_vec++;
    if ({rd_en, rd_addr, dp_data, dp_start, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h want 0",
               {rd_en, rd_addr, dp_data, dp_start, wr_en, wr_addr, wr_data, busy, done});
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
    clear_logs();
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if ({wd_log.size(), rd_cnt_m, done_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL rstmid_abandon: got wr=%0d rd=%0d done=%0d want 0/0/0", wd_log.size(), rd_cnt_m, done_cnt);
    end
    clear_logs();
    for (int i = 0; i < NUM_PIX; i++) exp_q.push_back(8'hA0 + 8'(i));
    pulse_start();
    wait_done(100, to);
    n_vec++;
    if (to !== 1'b0) begin n_err++; $display("FAIL rstmid_timeout: got timeout want done"); end
    n_vec++;
    if (wd_log.size() !== NUM_PIX) begin
      n_err++; $display("FAIL rstmid_write_count: got %0d want %0d", wd_log.size(), NUM_PIX);
    end
    for (int i = 0; i < wd_log.size() && i < NUM_PIX; i++) begin
      n_vec++;
      if ({wa_log[i], wd_log[i]} !== {ADDR_W'(i), exp_q[i]}) begin
        n_err++; $display("FAIL rstmid_write[%0d]: got %0d/%h want %0d/%h", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL rstmid_done: got %0d want 1", done_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_stall_hold();
    test_stall_toggle();
    test_restart_ignored();
    test_extremes();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_frame_ctrl.md
RGB_FRAME_CTRL -- requirements
Module: rgb_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIX, default 76800, meaning pixels per frame (320x240).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning read/write address width.
REQ-003 SHALL have parameter PIPE_LAT, default 3, meaning cycles from rd_en to valid gray_in (1 memory + 2 datapath).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning result buffer entries (power of 2, at least PIPE_LAT+1).
REQ-005 Port clk  input  1  system clock; one clock domain; rising edge.
REQ-006 Port n_rst  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  frame start request; sampled in IDLE only.
REQ-008 Port rd_en / rd_addr  output  1 / ADDR_W  RGB frame memory read strobe and address.
REQ-009 Port rd_data  input  24  RGB pixel returned one cycle after rd_en.
REQ-010 Port dp_data / dp_start  output  24 / 1  drive the RGB-to-gray datapath's data and startSignal.
REQ-011 Port gray_in  input  8  datapath finalOut.
REQ-012 Port wr_en / wr_addr / wr_data  output  1 / ADDR_W / 8  gray frame memory write.
REQ-013 Port wr_stall  input  1  when high, gray memory refuses writes this cycle.
REQ-014 Port busy / done  output  1 / 1  frame in progress; one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE->RUN on start=1; rd counter, wr counter and in-flight count SHALL clear on that transition.
REQ-017 RUN: rd_en=1 and rd_addr=rd counter in any cycle where inflight+fifo_count < FIFO_DEPTH; rd counter increments per issued read.
REQ-018 dp_data SHALL equal rd_data registered per the datapath contract; dp_start SHALL be 1 throughout RUN and DRAIN, 0 otherwise.
REQ-019 A valid-tag shift register of length PIPE_LAT SHALL track each rd_en; tag exit pushes gray_in into the FIFO.
REQ-020 Credit rule: FIFO SHALL never overflow; a push with the FIFO full is a design error (assertion).
REQ-021 wr_en=1 whenever FIFO non-empty and wr_stall=0; wr_data=FIFO head, wr_addr=wr counter; pop and wr counter increment on that cycle.
REQ-022 Simultaneous push and pop SHALL keep fifo_count unchanged; push to empty FIFO is writable no earlier than the next cycle.
REQ-023 RUN->DRAIN after the read with rd_addr=NUM_PIX-1 is issued; no rd_en in DRAIN.
REQ-024 DRAIN->DONE when the write with wr_addr=NUM_PIX-1 completes; DONE->IDLE unconditionally next cycle.
REQ-025 done SHALL be 1 exactly in DONE; busy SHALL be 1 in RUN and DRAIN.
REQ-026 start asserted while busy SHALL be ignored; no restart mid-frame.
REQ-027 Counters SHALL not wrap past NUM_PIX-1; addresses are pixel index, raster order, base 0.
REQ-028 Write order SHALL equal read order; every pixel written exactly once per frame.

Reset
REQ-029 n_rst low SHALL force IDLE, all counters, tags and FIFO pointers to 0, and all outputs to 0 immediately.
REQ-030 Reset mid-frame SHALL abandon the frame with no further rd_en/wr_en and no done pulse.

Structure
REQ-031 Package rgb_pkg SHALL hold the state enum, RGB_W=24, GRAY_W=8 and parameter defaults.
REQ-032 The result buffer SHALL be a sub-module gray_fifo (sync FIFO, count output); all other logic in rgb_frame_ctrl.

Verification
REQ-033 NUM_PIX=8, wr_stall=0, rd_data=index*0x010101, datapath model gray=R -> wr_data 0..7 at wr_addr 0..7, done 1 cycle, total latency NUM_PIX+PIPE_LAT+2.
REQ-034 wr_stall held high 10 cycles mid-frame -> rd_en stops once inflight+count=4, no FIFO overflow, no lost or duplicated writes.
REQ-035 wr_stall toggling every cycle -> all 8 writes in order, fifo_count never exceeds 4.
REQ-036 start pulsed again during RUN -> ignored; exactly 8 writes and one done.
REQ-037 n_rst low at pixel 4 -> all outputs 0 same cycle; a following start produces a complete frame from address 0.
REQ-038 rd_data=0xFFFFFF and 0x000000 -> wr_data 0xFF and 0x00 with correct addresses.
